pow2_clock_monitor: RTL



---
 rtl/pow2_clock_monitor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pow2_clock_monitor.sv
// rtl/pow2_clock_monitor.sv - divided-clock period checker with lock, enable pulse and sticky fault; optional stuck-clock timeout via POW2_CLKMON_TIMEOUT_EN
module pow2_clock_monitor #(
    parameter int DIV_LOG2    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int PERIOD_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_clk_div,
    output logic                io_enable,
    output logic                io_locked,
    output logic                io_fault,
    output logic [PERIOD_W-1:0] io_period
);
    localparam logic [PERIOD_W-1:0] PERIOD_EXP  = PERIOD_W'(1 << DIV_LOG2);
    localparam logic [PERIOD_W-1:0] CNT_MAX     = {PERIOD_W{1'b1}};
    localparam logic [3:0]          LOCK_TARGET = 4'(LOCK_COUNT);
`ifdef POW2_CLKMON_TIMEOUT_EN
    localparam logic [PERIOD_W-1:0] PERIOD_TIMEOUT = PERIOD_W'(2 << DIV_LOG2);
`endif

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [PERIOD_W-1:0]    cnt_q, cnt_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [3:0]             good_cnt_q, good_cnt_d;
    logic                   enable_q, enable_d;
    logic                   locked_q, locked_d;
    logic                   fault_q, fault_d;

    logic sync_out;
    logic rise;
    logic good;

    always_comb begin
        sync_d[0] = io_clk_div;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign prev_d   = sync_out;
    // On a rise cycle cnt_q holds the source cycles since the previous rise.
    assign good     = (cnt_q == PERIOD_EXP);

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        period_d   = period_q;
        fault_d    = fault_q;
        enable_d   = 1'b0;

        if (rise) begin
            cnt_d = PERIOD_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end

        if (rise) begin
            period_d = cnt_q;
            case (state_q)
                SEEK: begin
                    state_d    = TRACK;
                    good_cnt_d = 4'd0;
                end
                TRACK: begin
                    if (good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        fault_d = 1'b1;
                        state_d = SEEK;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        enable_d = 1'b1;
                    end else begin
                        fault_d = 1'b1;
                        state_d = SEEK;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
`ifdef POW2_CLKMON_TIMEOUT_EN
        else if (state_q != SEEK && cnt_q == PERIOD_TIMEOUT) begin
            fault_d = 1'b1;
            state_d = SEEK;
        end
`endif

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEEK;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            period_q   <= '0;
            good_cnt_q <= 4'd0;
            enable_q   <= 1'b0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            good_cnt_q <= good_cnt_d;
            enable_q   <= enable_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
        end
    end

    assign io_enable = enable_q;
    assign io_locked = locked_q;
    assign io_fault  = fault_q;
    assign io_period = period_q;

endmodule
